// File: rtl/clken_pkg.sv
// Shared types and constants for the clock-enable generator.
// Optional build macro used elsewhere in this slice: CLKEN_PHASE_EN.
package clken_pkg;

    // Divisor write port sequencing.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_WRAP = 1'b1
    } cfg_state_e;

    // Default counter width: wide enough for a 1 Hz tick at 50 MHz.
    localparam int DIV_W_DEF = 27;

    // Divisors for the legacy fixed rates at the 50 MHz system clock.
    localparam int DIV_12M5  = 4;
    localparam int DIV_1HZ   = 50_000_000;

endpackage

// File: rtl/clken_gen_if.sv
// Divisor write port: valid/ready handshake carrying target channel and divisor.
interface clken_gen_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 27
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clken_channel.sv
// One enable channel: up-counter, divisor register, wrap compare and pulse register.
// Priority inside a cycle: sync > step (paused) > counting; a load from the
// config FSM overrides the counter and divisor in whatever cycle it arrives.
module clken_channel #(
    parameter int               DIV_W   = 27,
    parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(4),
    parameter logic [DIV_W-1:0] PHASE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_div_i,
    output logic             wrap_o,
    output logic             clk_en_o
);

    // A divisor of zero behaves like one (enable permanently high).
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    // Restart value; a phase that would never be reached falls back to zero.
    function automatic logic [DIV_W-1:0] start_cnt(input logic [DIV_W-1:0] d);
        return (PHASE >= eff_div(d)) ? '0 : PHASE;
    endfunction

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;

    assign wrap_o   = run_i && !sync_i && (cnt_q == eff_div(div_q) - DIV_W'(1));
    assign clk_en_o = en_q;

    // Next counter, divisor and pulse value.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        en_d  = 1'b0;
        if (sync_i) begin
            cnt_d = start_cnt(div_q);
        end else if (!run_i) begin
            en_d = step_i;
        end else if (wrap_o) begin
            cnt_d = '0;
            en_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (load_i) begin
            div_d = load_div_i;
            cnt_d = start_cnt(load_div_i);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= start_cnt(DEF_DIV);
            div_q <= DEF_DIV;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator with glitch-free runtime divisor reload.
// Build macro CLKEN_PHASE_EN adds the PHASE parameter (per-channel restart offset).
// A new divisor is held in a shadow register and applied only when the target
// channel wraps, the block is paused, or a sync occurs, so no short pulses appear.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                   NCH     = 2,
    parameter int                   DIV_W   = DIV_W_DEF,
    parameter logic [NCH*DIV_W-1:0] DEF_DIV = {27'(DIV_1HZ), 27'(DIV_12M5)}
`ifdef CLKEN_PHASE_EN
    ,
    parameter logic [NCH*DIV_W-1:0] PHASE   = '0
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run_i,
    input  logic           step_i,
    input  logic           sync_i,
    clken_gen_if.slave     cfg,
    output logic [NCH-1:0] clk_en_o
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef CLKEN_PHASE_EN
    localparam logic [NCH*DIV_W-1:0] PHASE_L = PHASE;
`else
    localparam logic [NCH*DIV_W-1:0] PHASE_L = '0;
`endif

    cfg_state_e       state_q, state_d;
    logic [CH_W-1:0]  sh_ch_q, sh_ch_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             ready;
    logic             apply;
    logic             target_wrap;
    logic [NCH-1:0]   wrap_vec;
    logic [NCH-1:0]   apply_vec;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign apply_vec[i] = apply && (32'(sh_ch_q) == i);

        clken_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV[i*DIV_W +: DIV_W]),
            .PHASE   (PHASE_L[i*DIV_W +: DIV_W])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .run_i      (run_i),
            .step_i     (step_i),
            .sync_i     (sync_i),
            .load_i     (apply_vec[i]),
            .load_div_i (sh_div_q),
            .wrap_o     (wrap_vec[i]),
            .clk_en_o   (clk_en_o[i])
        );
    end

    assign cfg.cfg_ready = ready;

    // Wrap indication of the channel held in the shadow register.
    always_comb begin
        target_wrap = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(sh_ch_q) == i) begin
                target_wrap = wrap_vec[i];
            end
        end
    end

    // Config FSM: accept into shadow, then wait for a safe point to apply.
    always_comb begin
        state_d  = state_q;
        sh_ch_d  = sh_ch_q;
        sh_div_d = sh_div_q;
        ready    = 1'b0;
        apply    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (cfg.cfg_valid && (32'(cfg.cfg_ch) < NCH)) begin
                    sh_ch_d  = cfg.cfg_ch;
                    sh_div_d = cfg.cfg_div;
                    state_d  = WAIT_WRAP;
                end
            end
            WAIT_WRAP: begin
                if (target_wrap || !run_i || sync_i) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Config FSM state and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_ch_q  <= '0;
            sh_div_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_ch_q  <= sh_ch_d;
            sh_div_q <= sh_div_d;
        end
    end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: directed scenarios followed by random
// stimulus, all checked against a cycles-until-pulse reference model.
module tb_clken_gen;

    localparam int NCH   = 3;
    localparam int DIV_W = 8;
    localparam logic [NCH*DIV_W-1:0] DEF = {8'd7, 8'd200, 8'd4};

    logic clk = 1'b0;
    logic rst;
    logic run, step, sync;
    logic [NCH-1:0] clk_en;

    int passed = 0;
    int total  = 0;

    // Reference model: per channel, divisor and cycles remaining to next pulse.
    int  mdiv  [NCH];
    int  mleft [NCH];
    bit  pend;
    int  pch;
    int  pdiv;

    clken_gen_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    clken_gen #(
        .NCH     (NCH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_i    (run),
        .step_i   (step),
        .sync_i   (sync),
        .cfg      (bus.slave),
        .clk_en_o (clk_en)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mdiv[i]  = int'(DEF[i*DIV_W +: DIV_W]);
            mleft[i] = eff(mdiv[i]);
        end
        pend = 0;
    endtask

    // Advance the model by one clock with the current inputs, clock the DUT, compare.
    task automatic tick();
        logic [NCH-1:0] exp_en;
        bit apply;
        apply = pend && (sync || !run || mleft[pch] == 1);
        for (int i = 0; i < NCH; i++) begin
            exp_en[i] = 1'b0;
            if (sync) begin
                mleft[i] = eff(mdiv[i]);
            end else if (!run) begin
                exp_en[i] = step;
            end else if (mleft[i] == 1) begin
                exp_en[i] = 1'b1;
                mleft[i]  = eff(mdiv[i]);
            end else begin
                mleft[i]--;
            end
        end
        if (apply) begin
            mdiv[pch]  = pdiv;
            mleft[pch] = eff(pdiv);
            pend       = 0;
        end else if (!pend && bus.cfg_valid && int'(bus.cfg_ch) < NCH) begin
            pend = 1;
            pch  = int'(bus.cfg_ch);
            pdiv = int'(bus.cfg_div);
        end
        @(posedge clk);
        #1;
        check("en", 32'(clk_en), 32'(exp_en));
        check("ready", 32'(bus.cfg_ready), 32'(!pend));
    endtask

    task automatic ticks_to_en0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!clk_en[0] && n < 40);
    endtask

    task automatic cfg_write(input int ch, input int dv);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_div   = 8'(dv);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; run = 1'b1; step = 1'b0; sync = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_en", 32'(clk_en), 32'd0);
        check("rst_ready", 32'(bus.cfg_ready), 32'd1);
        rst = 1'b0;

        // 1: ch0 pulses on edges 4, 8, 12; ch1 first pulse on edge 200.
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t1_en0", 32'(clk_en[0]), 32'((k % 4) == 0));
        end
        n = 12;
        while (!clk_en[1] && n < 300) begin
            tick();
            n++;
        end
        check("t1_ch1_first", 32'(n), 32'd200);

        // 2: paused single steps hit every channel for one cycle.
        run = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick();
            check("t2_step", 32'(clk_en), 32'h7);
            step = 1'b0;
            repeat (4) tick();
        end

        // 3: ch0 div 4 -> 6 written at cnt=1; old pulse first, then period 6.
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run  = 1'b1;
        tick();
        cfg_write(0, 6);
        check("t3_busy", 32'(bus.cfg_ready), 32'd0);
        tick();
        check("t3_no_pulse", 32'(clk_en[0]), 32'd0);
        tick();
        check("t3_old_pulse", 32'(clk_en[0]), 32'd1);
        check("t3_ready_back", 32'(bus.cfg_ready), 32'd1);
        ticks_to_en0(n);
        check("t3_new_period", 32'(n), 32'd6);

        // 4: out-of-range channel is swallowed in one cycle.
        cfg_write(3, 1);
        check("t4_ready", 32'(bus.cfg_ready), 32'd1);
        repeat (14) tick();

        // 5b: reset during WAIT_WRAP restores defaults.
        cfg_write(1, 9);
        check("t5_busy", 32'(bus.cfg_ready), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_en", 32'(clk_en), 32'd0);
        check("t5_rst_ready", 32'(bus.cfg_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks_to_en0(n);
        check("t5_def_div", 32'(n), 32'd4);

        // 5a: mid-count sync clears pulses and restarts the count.
        repeat (2) tick();
        sync = 1'b1;
        tick();
        check("t5_sync_en", 32'(clk_en), 32'd0);
        sync = 1'b0;
        ticks_to_en0(n);
        check("t5_after_sync", 32'(n), 32'd4);

        // 6: divisor 0 behaves as 1 -> enable held high.
        cfg_write(0, 0);
        n = 0;
        while (!bus.cfg_ready && n < 20) begin
            tick();
            n++;
        end
        check("t6_applied", 32'(bus.cfg_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t6_const", 32'(clk_en[0]), 32'd1);
        end

        // Random mix of run/step/sync and divisor writes.
        for (int k = 0; k < 600; k++) begin
            run  = ($urandom_range(0, 9) != 0);
            step = ($urandom_range(0, 3) == 0);
            sync = ($urandom_range(0, 24) == 0);
            bus.cfg_valid = ($urandom_range(0, 2) == 0);
            bus.cfg_ch    = 2'($urandom_range(0, 3));
            bus.cfg_div   = 8'($urandom_range(0, 12));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
